pe_conv_mac_buffer_ctrl: RTL and testbench
==========================================

Name: pe_conv_mac_buffer_ctrl

Overview:
Sequencer for the conv MAC output gather buffer.
- Accepts pOUTPUT_PARALLEL-channel result slices from the MAC array through a valid/ready handshake.
- Drives the buffer's write enable and slice index, writing pOUT_CHANNEL/pOUTPUT_PARALLEL consecutive slices.
- Presents the assembled full-channel pixel downstream with valid/ready, tagging the last pixel of a frame.

Parameters:
pOUT_CHANNEL, 32, total output channels per pixel
pOUTPUT_PARALLEL, 32, channels produced per MAC beat; must divide pOUT_CHANNEL
pNUM_PIXEL, 1024, output pixels per frame; must be >= 1
Derived localparams: pGROUPS = pOUT_CHANNEL/pOUTPUT_PARALLEL; pIDX_W = max(1, $clog2(pGROUPS)); pPIX_W = max(1, $clog2(pNUM_PIXEL))

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
mac_valid  in  1  MAC slice valid
mac_ready  out  1  controller accepts slice this cycle
buf_wr_en  out  1  write strobe to buffer (combinational = mac_valid & mac_ready)
buf_idx  out  pIDX_W  slice index to buffer (registered group counter)
out_valid  out  1  assembled pixel available in buffer
out_ready  in  1  downstream accepts pixel
out_last  out  1  qualifies out_valid: last pixel of frame
busy  out  1  high when grp_cnt != 0, out_valid = 1, or pix_cnt != 0

Behaviour:
- Clock, reset and datapath:
  - One clock, clk. Reset rst is synchronous and active-high.
  - MAC data goes directly to the buffer; the controller carries no data.
- Reset values: mac_ready=1, buf_wr_en=0, buf_idx=0, out_valid=0, out_last=0, busy=0, grp_cnt=0, pix_cnt=0, state=FILL.
- FSM has two states.
  - FILL:
    - mac_ready=1.
    - On accept (mac_valid & mac_ready), the buffer writes slice grp_cnt.
    - If grp_cnt==pGROUPS-1: grp_cnt<=0, go to FULL, out_valid<=1. Otherwise grp_cnt++.
  - FULL:
    - out_valid=1; out_last = (pix_cnt==pNUM_PIXEL-1).
    - mac_ready = out_ready. Slice 0 of the next pixel may be written in the same cycle as the handshake, because data_out is sampled at that edge.
    - On out_ready, pix_cnt increments, wrapping to 0 after pNUM_PIXEL-1.
    - On out_ready, the next state is FILL with grp_cnt=1 if a slice was accepted in the same cycle, otherwise FILL with grp_cnt=0.
    - With pGROUPS==1, a same-cycle accept returns directly to FULL.
- Latency:
  - The last slice write and out_valid rise on the same edge.
  - out_valid is visible the cycle after the final accept.
- Backpressure:
  - While FULL and !out_ready: mac_ready=0, no write, and all counters hold.
  - out_valid stays high and out_last stays stable until the handshake.
- pGROUPS==1: buf_idx is tied to 0 and every accepted beat completes a pixel.
- Frame wrap: after out_last is handshaken, pix_cnt=0 and the next frame continues without idle cycles.
- Reset mid-operation: partial groups are abandoned, counters clear, and out_valid drops on the next cycle. Buffer contents are not the controller's concern.
- No combinational path from mac_valid to mac_ready. mac_ready depends on out_ready only in FULL.

Optional Feature:
Macro: PE_CONV_MAC_BUFFER_CTRL_PERF_EN
- Defined:
  - Adds output stall_cnt (32 bits), which counts cycles with out_valid & !out_ready.
  - Adds output starve_cnt (32 bits), which counts FILL cycles with !mac_valid.
  - Both counters saturate at 2^32-1 and are cleared by rst.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package pe_conv_pkg holds:
  - the state typedef enum logic {FILL, FULL};
  - a function that computes idx width as max(1, clog2(n)).
- Sub-module pe_perf_counter (saturating counter with enable) is used twice under the macro.
- The FSM and the group/pixel counters stay in the top module.

Test Plan:
- Reset check, pOUT_CHANNEL=32, pOUTPUT_PARALLEL=8 (pGROUPS=4): hold rst 2 cycles -> mac_ready=1, out_valid=0, buf_idx=0, busy=0.
- Continuous mac_valid, out_ready=1: buf_idx sequence 0,1,2,3,0,1… -> out_valid high exactly one cycle per pixel; no bubbles; the next pixel's slice 0 is written in the handshake cycle.
- Backpressure, out_ready=0 for 5 cycles after fill: mac_ready=0, buf_wr_en=0, buf_idx holds 0, out_valid held 5 cycles, stall_cnt=5 with PERF_EN.
- pNUM_PIXEL=3, run 7 pixels: out_last high on pixels 3 and 6 only; pix_cnt wraps to 0.
- Assert rst after 2 slices accepted -> next cycle grp_cnt=0, out_valid=0; a subsequent fill needs 4 fresh slices.
- pOUTPUT_PARALLEL=pOUT_CHANNEL (pGROUPS=1), continuous traffic, out_ready=1 -> buf_idx constant 0, out_valid every cycle after the first accept.

Source files
------------

// File: rtl/pe_conv_pkg.sv
// Shared types and helpers for the conv MAC output gather buffer.
package pe_conv_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } conv_state_e;

  // Index width for a counter over n values, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pe_perf_counter.sv
// Saturating event counter: increments once per enabled cycle and holds at all-ones.
// Synchronous active-high clear, no backpressure.
module pe_perf_counter #(
  parameter int pW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  output logic [pW-1:0] cnt_o
);

  logic [pW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + pW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pe_conv_mac_buffer_ctrl.sv
// Gather-buffer sequencer: out_valid rises the cycle after the final slice; mac_ready only drops in FULL while stalled.
// Optional stall/starve counters are built when PE_CONV_MAC_BUFFER_CTRL_PERF_EN is defined.
module pe_conv_mac_buffer_ctrl
  import pe_conv_pkg::*;
#(
  parameter int pOUT_CHANNEL     = 32,
  parameter int pOUTPUT_PARALLEL = 32,
  parameter int pNUM_PIXEL       = 1024,
  localparam int pGROUPS = pOUT_CHANNEL / pOUTPUT_PARALLEL,
  localparam int pIDX_W  = idx_w(pGROUPS),
  localparam int pPIX_W  = idx_w(pNUM_PIXEL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mac_valid,
  output logic              mac_ready,
  output logic              buf_wr_en,
  output logic [pIDX_W-1:0] buf_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
`ifdef PE_CONV_MAC_BUFFER_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       starve_cnt
`endif
);

  localparam logic [pIDX_W-1:0] GRP_LAST = pIDX_W'(pGROUPS - 1);
  localparam logic [pIDX_W-1:0] GRP_ONE  = pIDX_W'(1);
  localparam logic [pPIX_W-1:0] PIX_LAST = pPIX_W'(pNUM_PIXEL - 1);
  localparam logic [pPIX_W-1:0] PIX_ONE  = pPIX_W'(1);

  conv_state_e       state_q, state_d;
  logic [pIDX_W-1:0] grp_cnt_q, grp_cnt_d;
  logic [pPIX_W-1:0] pix_cnt_q, pix_cnt_d;

  always_comb begin
    state_d   = state_q;
    grp_cnt_d = grp_cnt_q;
    pix_cnt_d = pix_cnt_q;
    mac_ready = 1'b1;
    out_valid = 1'b0;
    out_last  = 1'b0;
    unique case (state_q)
      FILL: begin
        if (mac_valid) begin
          if (grp_cnt_q == GRP_LAST) begin
            grp_cnt_d = '0;
            state_d   = FULL;
          end else begin
            grp_cnt_d = grp_cnt_q + GRP_ONE;
          end
        end
      end
      FULL: begin
        // The buffer is read at the handshake edge, so slice 0 of the next pixel may land on that same edge.
        mac_ready = out_ready;
        out_valid = 1'b1;
        out_last  = (pix_cnt_q == PIX_LAST);
        if (out_ready) begin
          pix_cnt_d = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + PIX_ONE;
          if (mac_valid && (pGROUPS == 1)) begin
            state_d   = FULL;
            grp_cnt_d = '0;
          end else if (mac_valid) begin
            state_d   = FILL;
            grp_cnt_d = GRP_ONE;
          end else begin
            state_d   = FILL;
            grp_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      grp_cnt_q <= '0;
      pix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grp_cnt_q <= grp_cnt_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  assign buf_wr_en = mac_valid & mac_ready;

  generate
    if (pGROUPS == 1) begin : g_single_group
      assign buf_idx = '0;
    end else begin : g_multi_group
      assign buf_idx = grp_cnt_q;
    end
  endgenerate

  assign busy = (grp_cnt_q != '0) | out_valid | (pix_cnt_q != '0);

`ifdef PE_CONV_MAC_BUFFER_CTRL_PERF_EN
  pe_perf_counter #(.pW(32)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (out_valid & ~out_ready),
    .cnt_o (stall_cnt)
  );

  pe_perf_counter #(.pW(32)) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  ((state_q == FILL) & ~mac_valid),
    .cnt_o (starve_cnt)
  );
`endif

endmodule

// File: tb/tb_pe_conv_mac_buffer_ctrl.sv
// Directed bench: a 4-group/3-pixel instance and a single-group/4-pixel instance.
module tb_pe_conv_mac_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       mac_valid, out_ready;
  logic       mac_ready, buf_wr_en, out_valid, out_last, busy;
  logic [1:0] buf_idx;

  logic       mac_valid1, out_ready1;
  logic       mac_ready1, buf_wr_en1, out_valid1, out_last1, busy1;
  logic [0:0] buf_idx1;

`ifdef PE_CONV_MAC_BUFFER_CTRL_PERF_EN
  logic [31:0] stall_cnt, starve_cnt, stall_cnt1, starve_cnt1;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pe_conv_mac_buffer_ctrl #(
    .pOUT_CHANNEL(32), .pOUTPUT_PARALLEL(8), .pNUM_PIXEL(3)
  ) dut (
    .clk(clk), .rst(rst), .mac_valid(mac_valid), .mac_ready(mac_ready),
    .buf_wr_en(buf_wr_en), .buf_idx(buf_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy)
`ifdef PE_CONV_MAC_BUFFER_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .starve_cnt(starve_cnt)
`endif
  );

  pe_conv_mac_buffer_ctrl #(
    .pOUT_CHANNEL(32), .pOUTPUT_PARALLEL(32), .pNUM_PIXEL(4)
  ) dut1 (
    .clk(clk), .rst(rst), .mac_valid(mac_valid1), .mac_ready(mac_ready1),
    .buf_wr_en(buf_wr_en1), .buf_idx(buf_idx1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_last(out_last1), .busy(busy1)
`ifdef PE_CONV_MAC_BUFFER_CTRL_PERF_EN
    , .stall_cnt(stall_cnt1), .starve_cnt(starve_cnt1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mac_valid = 1'b0; out_ready = 1'b0;
    mac_valid1 = 1'b0; out_ready1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mac_valid = 1'b0; out_ready = 1'b0;
    mac_valid1 = 1'b0; out_ready1 = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (mac_ready !== 1'b1) begin errs++; $display("FAIL reset_mac_ready got=%b want=1", mac_ready); end
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errs++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    checks++; if (buf_idx !== 2'd0) begin errs++; $display("FAIL reset_buf_idx got=%0d want=0", buf_idx); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (buf_wr_en !== 1'b0) begin errs++; $display("FAIL reset_buf_wr_en got=%b want=0", buf_wr_en); end
    checks++; if (out_valid1 !== 1'b0 || busy1 !== 1'b0 || mac_ready1 !== 1'b1) begin
      errs++; $display("FAIL reset_g1 got ov=%b busy=%b rdy=%b want 0 0 1", out_valid1, busy1, mac_ready1);
    end
`ifdef PE_CONV_MAC_BUFFER_CTRL_PERF_EN
    checks++; if (stall_cnt !== 32'd0 || starve_cnt !== 32'd0) begin
      errs++; $display("FAIL reset_perf got stall=%0d starve=%0d want 0 0", stall_cnt, starve_cnt);
    end
`endif
    rst = 1'b0;
  endtask

  // Continuous traffic over 7 pixels with a 3-pixel frame: lasts on pixels 3 and 6.
  task automatic test_stream_frame_wrap();
    int n_last;
    logic exp_ov, exp_last;
    do_reset();
    mac_valid = 1'b1; out_ready = 1'b1;
    n_last = 0;
    for (int k = 0; k <= 28; k++) begin
      #1;
      exp_ov   = (k >= 4) && (k % 4 == 0);
      exp_last = exp_ov && (((k / 4) - 1) % 3 == 2);
      checks++; if (buf_idx !== 2'(k % 4)) begin errs++; $display("FAIL stream_idx k=%0d got=%0d want=%0d", k, buf_idx, k % 4); end
      checks++; if (buf_wr_en !== 1'b1 || mac_ready !== 1'b1) begin errs++; $display("FAIL stream_wr k=%0d got wr=%b rdy=%b want 1 1", k, buf_wr_en, mac_ready); end
      checks++; if (out_valid !== exp_ov) begin errs++; $display("FAIL stream_ov k=%0d got=%b want=%b", k, out_valid, exp_ov); end
      checks++; if (out_last !== exp_last) begin errs++; $display("FAIL stream_last k=%0d got=%b want=%b", k, out_last, exp_last); end
      if (out_valid === 1'b1 && out_last === 1'b1) n_last++;
      tick();
    end
    checks++; if (n_last != 2) begin errs++; $display("FAIL stream_last_count got=%0d want=2", n_last); end
    mac_valid = 1'b0;
    #1;
    checks++; if (buf_idx !== 2'd1 || out_valid !== 1'b0) begin
      errs++; $display("FAIL stream_tail got idx=%0d ov=%b want 1 0", buf_idx, out_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (mac_ready !== 1'b1 || buf_wr_en !== 1'b0) begin errs++; $display("FAIL bp_idle k=%0d got rdy=%b wr=%b want 1 0", k, mac_ready, buf_wr_en); end
      tick();
    end
    mac_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (buf_idx !== 2'(k) || buf_wr_en !== 1'b1) begin errs++; $display("FAIL bp_fill k=%0d got idx=%0d wr=%b want %0d 1", k, buf_idx, buf_wr_en, k); end
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (mac_ready !== 1'b0) begin errs++; $display("FAIL bp_mac_ready k=%0d got=%b want=0", k, mac_ready); end
      checks++; if (buf_wr_en !== 1'b0) begin errs++; $display("FAIL bp_wr k=%0d got=%b want=0", k, buf_wr_en); end
      checks++; if (buf_idx !== 2'd0) begin errs++; $display("FAIL bp_idx k=%0d got=%0d want=0", k, buf_idx); end
      checks++; if (out_valid !== 1'b1 || out_last !== 1'b0 || busy !== 1'b1) begin
        errs++; $display("FAIL bp_hold k=%0d got ov=%b last=%b busy=%b want 1 0 1", k, out_valid, out_last, busy);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (buf_wr_en !== 1'b1 || out_valid !== 1'b1 || buf_idx !== 2'd0) begin
      errs++; $display("FAIL bp_release got wr=%b ov=%b idx=%0d want 1 1 0", buf_wr_en, out_valid, buf_idx);
    end
`ifdef PE_CONV_MAC_BUFFER_CTRL_PERF_EN
    checks++; if (stall_cnt !== 32'd5) begin errs++; $display("FAIL bp_stall_cnt got=%0d want=5", stall_cnt); end
    checks++; if (starve_cnt !== 32'd3) begin errs++; $display("FAIL bp_starve_cnt got=%0d want=3", starve_cnt); end
`endif
    tick();
    mac_valid = 1'b0;
    #1;
    checks++; if (buf_idx !== 2'd1 || out_valid !== 1'b0) begin
      errs++; $display("FAIL bp_after got idx=%0d ov=%b want 1 0", buf_idx, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mac_valid = 1'b1; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1; mac_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (buf_idx !== 2'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL rstmid_clear got idx=%0d ov=%b busy=%b want 0 0 0", buf_idx, out_valid, busy);
    end
    mac_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (buf_idx !== 2'(k) || out_valid !== 1'b0) begin
        errs++; $display("FAIL rstmid_refill k=%0d got idx=%0d ov=%b want %0d 0", k, buf_idx, out_valid, k);
      end
      tick();
    end
    #1;
    checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL rstmid_full got=%b want=1", out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0; mac_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL rstmid_drop got ov=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_single_group();
    logic exp_ov, exp_last;
    do_reset();
    mac_valid1 = 1'b1; out_ready1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      exp_ov   = (k >= 1);
      exp_last = (k >= 1) && ((k - 1) % 4 == 3);
      checks++; if (buf_idx1 !== 1'b0 || buf_wr_en1 !== 1'b1) begin errs++; $display("FAIL g1_wr k=%0d got idx=%0d wr=%b want 0 1", k, buf_idx1, buf_wr_en1); end
      checks++; if (out_valid1 !== exp_ov) begin errs++; $display("FAIL g1_ov k=%0d got=%b want=%b", k, out_valid1, exp_ov); end
      checks++; if (out_last1 !== exp_last) begin errs++; $display("FAIL g1_last k=%0d got=%b want=%b", k, out_last1, exp_last); end
      tick();
    end
    out_ready1 = 1'b0;
    #1;
    checks++; if (mac_ready1 !== 1'b0 || buf_wr_en1 !== 1'b0 || out_valid1 !== 1'b1 || out_last1 !== 1'b0) begin
      errs++; $display("FAIL g1_stall got rdy=%b wr=%b ov=%b last=%b want 0 0 1 0", mac_ready1, buf_wr_en1, out_valid1, out_last1);
    end
    tick();
    mac_valid1 = 1'b0; out_ready1 = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream_frame_wrap();
    test_backpressure();
    test_reset_mid();
    test_single_group();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
